// File: rtl/i2c_slave_write_sequencer_if.sv
// Bus bundle between the I2C pads / display register bank and i2c_slave_write_sequencer.
// The slave modport is the sequencer's view; master is the driver side (pads + bank).
interface i2c_slave_write_sequencer_if #(
   parameter int NUM_BYTES = 6
);
   localparam int AW = (NUM_BYTES > 1) ? $clog2(NUM_BYTES) : 1;

   logic          SCL;
   logic          SDA;
   logic          enable;
   logic          SDA_down;
   logic          wr_en;
   logic [AW-1:0] wr_addr;
   logic [7:0]    wr_data;
   logic          frame_done;
   logic          busy;

   modport slave (
      input  SCL, SDA, enable,
      output SDA_down, wr_en, wr_addr, wr_data, frame_done, busy
   );

   modport master (
      output SCL, SDA, enable,
      input  SDA_down, wr_en, wr_addr, wr_data, frame_done, busy
   );
endinterface

// File: rtl/i2c_slave_write_sequencer.sv
// I2C slave receive-path controller: ACKs writes to SLAVE_ADDR and streams up to NUM_BYTES
// data bytes into a byte-wide register-file write port. Optional macro: GENERAL_CALL_EN.
module i2c_slave_write_sequencer #(
   parameter logic [6:0] SLAVE_ADDR  = 7'h42,
   parameter int         NUM_BYTES   = 6,
   parameter int         SYNC_STAGES = 2
) (
   input logic FPGA_clk,
   input logic rst,
   i2c_slave_write_sequencer_if.slave bus
);
   localparam int AW = (NUM_BYTES > 1) ? $clog2(NUM_BYTES) : 1;
   localparam int CW = $clog2(NUM_BYTES + 1);
   localparam logic [CW-1:0] BYTE_LIMIT = CW'(NUM_BYTES);

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_ADDR,
      ST_ADDR_ACK,
      ST_DATA,
      ST_DATA_ACK,
      ST_IGNORE
   } state_t;

   state_t                 state_q, state_d;
   logic [SYNC_STAGES-1:0] scl_sync_q, scl_sync_d;
   logic [SYNC_STAGES-1:0] sda_sync_q, sda_sync_d;
   logic                   scl_prev_q, scl_prev_d;
   logic                   sda_prev_q, sda_prev_d;
   logic [7:0]             shift_q, shift_d;
   logic [2:0]             bit_cnt_q, bit_cnt_d;
   logic                   byte_full_q, byte_full_d;
   logic                   match_q, match_d;
   logic [CW-1:0]          byte_cnt_q, byte_cnt_d;
   logic                   sda_down_q, sda_down_d;
   logic                   wr_en_q, wr_en_d;
   logic [AW-1:0]          wr_addr_q, wr_addr_d;
   logic [7:0]             wr_data_q, wr_data_d;
   logic                   frame_done_q, frame_done_d;
   logic                   busy_q, busy_d;

   logic       scl_s, sda_s;
   logic       scl_rise, scl_fall;
   logic       start_det, stop_det;
   logic [7:0] addr_byte;
   logic       addr_hit;

   assign scl_s     = scl_sync_q[SYNC_STAGES-1];
   assign sda_s     = sda_sync_q[SYNC_STAGES-1];
   assign scl_rise  = scl_s & ~scl_prev_q;
   assign scl_fall  = ~scl_s & scl_prev_q;
   assign start_det = scl_s & sda_prev_q & ~sda_s;
   assign stop_det  = scl_s & ~sda_prev_q & sda_s;

   // Address byte as it stands once the 8th bit is shifted in; bit 0 is R/W (0 = write).
   assign addr_byte = {shift_q[6:0], sda_s};
`ifdef GENERAL_CALL_EN
   assign addr_hit = ((addr_byte[7:1] == SLAVE_ADDR) && !addr_byte[0]) || (addr_byte == 8'h00);
`else
   assign addr_hit = (addr_byte[7:1] == SLAVE_ADDR) && !addr_byte[0];
`endif

   always_comb begin
      state_d      = state_q;
      scl_sync_d   = {scl_sync_q[SYNC_STAGES-2:0], bus.SCL};
      sda_sync_d   = {sda_sync_q[SYNC_STAGES-2:0], bus.SDA};
      scl_prev_d   = scl_s;
      sda_prev_d   = sda_s;
      shift_d      = shift_q;
      bit_cnt_d    = bit_cnt_q;
      byte_full_d  = byte_full_q;
      match_d      = match_q;
      byte_cnt_d   = byte_cnt_q;
      sda_down_d   = sda_down_q;
      wr_en_d      = 1'b0;
      wr_addr_d    = wr_addr_q;
      wr_data_d    = wr_data_q;
      frame_done_d = 1'b0;

      // Framing events outrank bit sampling; a half-received byte is simply dropped.
      if (!bus.enable) begin
         state_d     = ST_IDLE;
         sda_down_d  = 1'b0;
         bit_cnt_d   = 3'd0;
         byte_full_d = 1'b0;
         byte_cnt_d  = '0;
      end else if (stop_det) begin
         state_d      = ST_IDLE;
         sda_down_d   = 1'b0;
         frame_done_d = (byte_cnt_q != '0);
         bit_cnt_d    = 3'd0;
         byte_full_d  = 1'b0;
         byte_cnt_d   = '0;
      end else if (start_det) begin
         state_d     = ST_ADDR;
         sda_down_d  = 1'b0;
         bit_cnt_d   = 3'd0;
         byte_full_d = 1'b0;
      end else begin
         case (state_q)
            ST_ADDR, ST_DATA: begin
               if (scl_rise && !byte_full_q) begin
                  shift_d   = {shift_q[6:0], sda_s};
                  bit_cnt_d = bit_cnt_q + 3'd1;
                  if (bit_cnt_q == 3'd7) begin
                     byte_full_d = 1'b1;
                     if (state_q == ST_ADDR) begin
                        match_d = addr_hit;
                     end
                  end
               end else if (scl_fall && byte_full_q) begin
                  byte_full_d = 1'b0;
                  if (state_q == ST_ADDR) begin
                     state_d = match_q ? ST_ADDR_ACK : ST_IGNORE;
                  end else if (byte_cnt_q < BYTE_LIMIT) begin
                     wr_en_d    = 1'b1;
                     wr_addr_d  = AW'(byte_cnt_q);
                     wr_data_d  = shift_q;
                     byte_cnt_d = byte_cnt_q + 1'b1;
                     state_d    = ST_DATA_ACK;
                  end else begin
                     state_d = ST_IGNORE;
                  end
               end
            end
            // Hold SDA low through the whole ACK clock; let go once SCL falls again.
            ST_ADDR_ACK, ST_DATA_ACK: begin
               if (scl_fall) begin
                  sda_down_d = 1'b0;
                  state_d    = ST_DATA;
               end else begin
                  sda_down_d = 1'b1;
               end
            end
            ST_IGNORE: sda_down_d = 1'b0;
            default:   sda_down_d = 1'b0;
         endcase
      end

      busy_d = (state_d != ST_IDLE);
   end

   // Input synchronizers idle high so a reset release never looks like bus activity.
   always_ff @(posedge FPGA_clk) begin
      if (!rst) begin
         state_q      <= ST_IDLE;
         scl_sync_q   <= '1;
         sda_sync_q   <= '1;
         scl_prev_q   <= 1'b1;
         sda_prev_q   <= 1'b1;
         shift_q      <= 8'd0;
         bit_cnt_q    <= 3'd0;
         byte_full_q  <= 1'b0;
         match_q      <= 1'b0;
         byte_cnt_q   <= '0;
         sda_down_q   <= 1'b0;
         wr_en_q      <= 1'b0;
         wr_addr_q    <= '0;
         wr_data_q    <= 8'd0;
         frame_done_q <= 1'b0;
         busy_q       <= 1'b0;
      end else begin
         state_q      <= state_d;
         scl_sync_q   <= scl_sync_d;
         sda_sync_q   <= sda_sync_d;
         scl_prev_q   <= scl_prev_d;
         sda_prev_q   <= sda_prev_d;
         shift_q      <= shift_d;
         bit_cnt_q    <= bit_cnt_d;
         byte_full_q  <= byte_full_d;
         match_q      <= match_d;
         byte_cnt_q   <= byte_cnt_d;
         sda_down_q   <= sda_down_d;
         wr_en_q      <= wr_en_d;
         wr_addr_q    <= wr_addr_d;
         wr_data_q    <= wr_data_d;
         frame_done_q <= frame_done_d;
         busy_q       <= busy_d;
      end
   end

   assign bus.SDA_down   = sda_down_q;
   assign bus.wr_en      = wr_en_q;
   assign bus.wr_addr    = wr_addr_q;
   assign bus.wr_data    = wr_data_q;
   assign bus.frame_done = frame_done_q;
   assign bus.busy       = busy_q;
endmodule

// File: tb/tb_i2c_slave_write_sequencer.sv
// Testbench for i2c_slave_write_sequencer: bit-level I2C master with an open-drain SDA line
// and a frame-level reference model of which bytes get ACKed and written.
module tb_i2c_slave_write_sequencer;
   localparam int H  = 8;
   localparam int NB = 6;

   logic FPGA_clk = 1'b0;
   logic rst;
   logic scl_m, sda_m, en_m;

   int  tests;
   int  fails;
   int  obs_q[$];
   int  fd_count;
   bit  sda_seen;
   bit  gc_en;

   byte unsigned seg_addr[4];
   int           seg_n[4];
   byte unsigned seg_data[4][10];
   int           nseg;

   i2c_slave_write_sequencer_if #(.NUM_BYTES(NB)) bus ();

   assign bus.SCL    = scl_m;
   assign bus.SDA    = sda_m & ~bus.SDA_down;
   assign bus.enable = en_m;

   i2c_slave_write_sequencer #(
      .SLAVE_ADDR (7'h42),
      .NUM_BYTES  (NB),
      .SYNC_STAGES(2)
   ) dut (
      .FPGA_clk(FPGA_clk),
      .rst     (rst),
      .bus     (bus)
   );

   always #5 FPGA_clk = ~FPGA_clk;

   // Record every write strobe, frame_done pulse and any SDA pulldown.
   always @(negedge FPGA_clk) begin
      if (bus.wr_en === 1'b1) obs_q.push_back(int'(bus.wr_addr) * 256 + int'(bus.wr_data));
      if (bus.frame_done === 1'b1) fd_count++;
      if (bus.SDA_down === 1'b1) sda_seen = 1'b1;
   end

   task automatic wait_clks(input int n);
      repeat (n) @(negedge FPGA_clk);
   endtask

   task automatic send_start();
      sda_m = 1'b1; wait_clks(H);
      scl_m = 1'b1; wait_clks(H);
      sda_m = 1'b0; wait_clks(H);
      scl_m = 1'b0; wait_clks(H);
   endtask

   task automatic send_bit(input bit b);
      sda_m = b;    wait_clks(H);
      scl_m = 1'b1; wait_clks(H);
      scl_m = 1'b0; wait_clks(H);
   endtask

   task automatic send_byte(input byte unsigned b, output bit ack);
      for (int i = 7; i >= 0; i--) send_bit(b[i]);
      sda_m = 1'b1; wait_clks(H);
      scl_m = 1'b1; wait_clks(H / 2);
      ack = bus.SDA_down;
      wait_clks(H / 2);
      scl_m = 1'b0; wait_clks(H);
   endtask

   task automatic send_stop();
      sda_m = 1'b0; wait_clks(H);
      scl_m = 1'b1; wait_clks(H);
      sda_m = 1'b1; wait_clks(H);
   endtask

   // Drives the frame described by seg_* and checks it against the frame-level model.
   task automatic play_frame(input string name);
      int exp_q[$];
      int cnt;
      int exp_fd;
      bit mode;
      bit match;
      bit ack;
      bit exp_ack;
      cnt = 0;
      obs_q.delete();
      fd_count = 0;
      for (int s = 0; s < nseg; s++) begin
         match = ((seg_addr[s][7:1] == 7'h42) && !seg_addr[s][0]) || (gc_en && seg_addr[s] == 8'h00);
         mode  = match;
         send_start();
         send_byte(seg_addr[s], ack);
         tests++;
         if (ack !== match) begin
            fails++;
            $display("[TB] FAIL %s addr_ack seg%0d: got %0b want %0b", name, s, ack, match);
         end
         for (int k = 0; k < seg_n[s]; k++) begin
            exp_ack = mode && (cnt < NB);
            if (exp_ack) begin
               exp_q.push_back(cnt * 256 + int'(seg_data[s][k]));
               cnt++;
            end else begin
               mode = 1'b0;
            end
            send_byte(seg_data[s][k], ack);
            tests++;
            if (ack !== exp_ack) begin
               fails++;
               $display("[TB] FAIL %s data_ack seg%0d byte%0d: got %0b want %0b", name, s, k, ack, exp_ack);
            end
         end
      end
      tests++;
      if (bus.busy !== 1'b1) begin
         fails++;
         $display("[TB] FAIL %s busy_before_stop: got %0b want 1", name, bus.busy);
      end
      send_stop();
      wait_clks(10);
      exp_fd = (cnt > 0) ? 1 : 0;
      tests++;
      if (obs_q.size() != exp_q.size()) begin
         fails++;
         $display("[TB] FAIL %s write_count: got %0d want %0d", name, obs_q.size(), exp_q.size());
      end
      for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
         tests++;
         if (obs_q[i] != exp_q[i]) begin
            fails++;
            $display("[TB] FAIL %s write%0d: got addr %0d data %02h want addr %0d data %02h",
                     name, i, obs_q[i] / 256, obs_q[i] % 256, exp_q[i] / 256, exp_q[i] % 256);
         end
      end
      tests++;
      if (fd_count != exp_fd) begin
         fails++;
         $display("[TB] FAIL %s frame_done: got %0d want %0d", name, fd_count, exp_fd);
      end
      tests++;
      if (bus.busy !== 1'b0) begin
         fails++;
         $display("[TB] FAIL %s busy_after_stop: got %0b want 0", name, bus.busy);
      end
   endtask

   task automatic test_reset();
      rst = 1'b0; scl_m = 1'b1; sda_m = 1'b1; en_m = 1'b1;
      wait_clks(3);
      tests += 6;
      if (bus.SDA_down !== 1'b0)   begin fails++; $display("[TB] FAIL reset SDA_down: got %0b want 0", bus.SDA_down); end
      if (bus.wr_en !== 1'b0)      begin fails++; $display("[TB] FAIL reset wr_en: got %0b want 0", bus.wr_en); end
      if (bus.wr_addr !== '0)      begin fails++; $display("[TB] FAIL reset wr_addr: got %0d want 0", bus.wr_addr); end
      if (bus.wr_data !== 8'h00)   begin fails++; $display("[TB] FAIL reset wr_data: got %02h want 00", bus.wr_data); end
      if (bus.frame_done !== 1'b0) begin fails++; $display("[TB] FAIL reset frame_done: got %0b want 0", bus.frame_done); end
      if (bus.busy !== 1'b0)       begin fails++; $display("[TB] FAIL reset busy: got %0b want 0", bus.busy); end
      rst = 1'b1;
      wait_clks(5);
   endtask

   task automatic test_write_frame();
      nseg = 1; seg_addr[0] = 8'h84; seg_n[0] = 3;
      seg_data[0][0] = 8'h12; seg_data[0][1] = 8'h34; seg_data[0][2] = 8'h56;
      play_frame("write_frame");
   endtask

   task automatic test_mismatch();
      sda_seen = 1'b0;
      nseg = 1; seg_addr[0] = 8'h86; seg_n[0] = 2;
      seg_data[0][0] = 8'h00; seg_data[0][1] = 8'hFF;
      play_frame("mismatch_addr");
      seg_addr[0] = 8'h85;
      play_frame("read_bit");
      tests++;
      if (sda_seen !== 1'b0) begin
         fails++;
         $display("[TB] FAIL mismatch SDA_down_seen: got %0b want 0", sda_seen);
      end
   endtask

   task automatic test_overflow();
      nseg = 1; seg_addr[0] = 8'h84; seg_n[0] = 8;
      for (int i = 0; i < 8; i++) seg_data[0][i] = 8'(i);
      play_frame("overflow");
   endtask

   task automatic test_repeated_start();
      nseg = 2;
      seg_addr[0] = 8'h84; seg_n[0] = 2; seg_data[0][0] = 8'hA1; seg_data[0][1] = 8'hB2;
      seg_addr[1] = 8'h84; seg_n[1] = 1; seg_data[1][0] = 8'hC3;
      play_frame("repeated_start");
   endtask

   task automatic test_partial_byte();
      bit ack;
      obs_q.delete(); fd_count = 0;
      send_start();
      send_byte(8'h84, ack);
      tests++;
      if (ack !== 1'b1) begin fails++; $display("[TB] FAIL partial addr_ack: got %0b want 1", ack); end
      send_bit(1'b1); send_bit(1'b0); send_bit(1'b1); send_bit(1'b1);
      send_stop();
      wait_clks(10);
      tests += 2;
      if (obs_q.size() != 0) begin fails++; $display("[TB] FAIL partial writes: got %0d want 0", obs_q.size()); end
      if (fd_count != 0)     begin fails++; $display("[TB] FAIL partial frame_done: got %0d want 0", fd_count); end
   endtask

   task automatic test_reset_in_ack();
      obs_q.delete(); fd_count = 0;
      send_start();
      for (int i = 7; i >= 0; i--) send_bit(1'(8'h84 >> i));
      sda_m = 1'b1;
      for (int i = 0; i < 20 && bus.SDA_down !== 1'b1; i++) wait_clks(1);
      tests++;
      if (bus.SDA_down !== 1'b1) begin
         fails++;
         $display("[TB] FAIL rst_in_ack ack_timeout: got SDA_down %0b want 1", bus.SDA_down);
      end
      rst = 1'b0;
      wait_clks(1);
      tests += 2;
      if (bus.SDA_down !== 1'b0) begin fails++; $display("[TB] FAIL rst_in_ack SDA_down: got %0b want 0", bus.SDA_down); end
      if (bus.busy !== 1'b0)     begin fails++; $display("[TB] FAIL rst_in_ack busy: got %0b want 0", bus.busy); end
      scl_m = 1'b1; sda_m = 1'b1;
      wait_clks(3);
      rst = 1'b1;
      wait_clks(5);
      tests += 2;
      if (obs_q.size() != 0) begin fails++; $display("[TB] FAIL rst_in_ack writes: got %0d want 0", obs_q.size()); end
      if (fd_count != 0)     begin fails++; $display("[TB] FAIL rst_in_ack frame_done: got %0d want 0", fd_count); end
   endtask

   task automatic test_enable_low();
      bit ack;
      obs_q.delete(); fd_count = 0;
      en_m = 1'b0;
      send_start();
      send_byte(8'h84, ack);
      tests += 2;
      if (ack !== 1'b0)      begin fails++; $display("[TB] FAIL enable_low ack: got %0b want 0", ack); end
      if (bus.busy !== 1'b0) begin fails++; $display("[TB] FAIL enable_low busy: got %0b want 0", bus.busy); end
      send_stop();
      wait_clks(10);
      tests += 2;
      if (obs_q.size() != 0) begin fails++; $display("[TB] FAIL enable_low writes: got %0d want 0", obs_q.size()); end
      if (fd_count != 0)     begin fails++; $display("[TB] FAIL enable_low frame_done: got %0d want 0", fd_count); end
      en_m = 1'b1;
      wait_clks(5);
   endtask

   task automatic test_general_call();
      nseg = 1; seg_addr[0] = 8'h00; seg_n[0] = 1; seg_data[0][0] = 8'hAB;
      play_frame("general_call");
   endtask

   task automatic test_random();
      int sel;
      for (int f = 0; f < 6; f++) begin
         nseg = int'($urandom_range(1, 2));
         for (int s = 0; s < nseg; s++) begin
            sel = int'($urandom_range(0, 3));
            case (sel)
               0:       seg_addr[s] = 8'h84;
               1:       seg_addr[s] = 8'h85;
               2:       seg_addr[s] = 8'($urandom_range(0, 255));
               default: seg_addr[s] = 8'h00;
            endcase
            seg_n[s] = int'($urandom_range(0, 8));
            for (int k = 0; k < 10; k++) seg_data[s][k] = 8'($urandom_range(0, 255));
         end
         play_frame($sformatf("random%0d", f));
      end
   endtask

   initial begin
      tests = 0; fails = 0; fd_count = 0; sda_seen = 1'b0;
      scl_m = 1'b1; sda_m = 1'b1; en_m = 1'b1; rst = 1'b0; nseg = 0;
`ifdef GENERAL_CALL_EN
      gc_en = 1'b1;
`else
      gc_en = 1'b0;
`endif
      test_reset();
      test_write_frame();
      test_mismatch();
      test_overflow();
      test_repeated_start();
      test_partial_byte();
      test_reset_in_ack();
      test_enable_low();
      test_general_call();
      test_random();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
